// File: rtl/dht11_pkg.sv
// Shared definitions for the DHT11 measurement scheduler: FSM state codes, error codes,
// frame byte positions and the frame checksum helper.
// No timing or flow control of its own; pure constants and functions.
package dht11_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_GAP   = 3'd1;
    localparam state_t ST_TRIG  = 3'd2;
    localparam state_t ST_WAIT  = 3'd3;
    localparam state_t ST_CHECK = 3'd4;
    localparam state_t ST_FAIL  = 3'd5;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_TIMEOUT = 2'b01;
    localparam logic [1:0] ERR_CSUM    = 2'b10;

    localparam int RH_INT_LSB = 32;
    localparam int RH_DEC_LSB = 24;
    localparam int T_INT_LSB  = 16;
    localparam int T_DEC_LSB  = 8;
    localparam int CSUM_LSB   = 0;

    function automatic logic [7:0] frame_csum(input logic [39:0] f);
        return f[RH_INT_LSB +: 8] + f[RH_DEC_LSB +: 8] + f[T_INT_LSB +: 8] + f[T_DEC_LSB +: 8];
    endfunction

    function automatic logic frame_ok(input logic [39:0] f);
        return frame_csum(f) == f[CSUM_LSB +: 8];
    endfunction

endpackage

// File: rtl/dht11_ms_tick.sv
// Millisecond prescaler: one-cycle tick every DIV clocks.
// Latency: tick registered, first tick DIV cycles after reset release.
// Backpressure: none; free-running.
module dht11_ms_tick #(
    parameter int DIV = 100_000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            tick <= (cnt == LAST);
            cnt  <= (cnt == LAST) ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/dht11_sched.sv
// DHT11 conversion scheduler: paces start pulses, times out, checks frames, publishes data.
// Latency: req -> start 2 cycles when gap satisfied; done -> upd/err 2 cycles. Retry build: DHT11_SCHED_RETRY_EN.
// Backpressure: none; requests while one is pending collapse into a single conversion.
module dht11_sched #(
    parameter int CLK_HZ          = 100_000_000,
    parameter int MIN_INTERVAL_MS = 1000,
    parameter int PERIOD_MS       = 2000,
    parameter int TIMEOUT_MS      = 50,
    parameter int MAX_RETRY       = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        auto_en,
    output logic        start,
    input  logic        done,
    input  logic [39:0] frame,
    output logic [7:0]  humid,
    output logic [7:0]  humid_dec,
    output logic [7:0]  temp,
    output logic [7:0]  temp_dec,
    output logic        valid,
    output logic        upd,
    output logic        err,
    output logic [1:0]  err_code,
    output logic        busy
);
    import dht11_pkg::*;

    localparam int GAP_W = $clog2(MIN_INTERVAL_MS + 1);
    localparam int PER_W = $clog2(PERIOD_MS + 1);
    localparam int TO_W  = $clog2(TIMEOUT_MS + 1);
    localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(MIN_INTERVAL_MS);
    localparam logic [PER_W-1:0] PER_MAX = PER_W'(PERIOD_MS - 1);
    localparam logic [TO_W-1:0]  TO_MAX  = TO_W'(TIMEOUT_MS);

    logic             tick;
    state_t           state, state_nxt;
    logic             pend, gap_skip;
    logic [GAP_W-1:0] gap_cnt;
    logic [PER_W-1:0] per_cnt;
    logic [TO_W-1:0]  to_cnt;
    logic [39:0]      frame_q;
    logic             gap_ok, to_hit, frame_good, trig_go, per_wrap;
    logic             fail_go, retry_left;
    logic [1:0]       fail_code;

    dht11_ms_tick #(.DIV(CLK_HZ / 1000)) u_ms_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    assign gap_ok     = (gap_cnt == GAP_MAX);
    assign to_hit     = (to_cnt == TO_MAX);
    assign frame_good = frame_ok(frame_q);
    assign per_wrap   = tick && (per_cnt == PER_MAX);

    always_comb begin
        state_nxt = state;
        fail_go   = 1'b0;
        fail_code = ERR_NONE;
        case (state)
            ST_IDLE:  if (pend) state_nxt = gap_ok ? ST_TRIG : ST_GAP;
            ST_GAP:   if (gap_ok) state_nxt = ST_TRIG;
            ST_TRIG:  state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (done) begin
                    state_nxt = ST_CHECK;
                end else if (to_hit) begin
                    state_nxt = ST_FAIL;
                    fail_go   = 1'b1;
                    fail_code = ERR_TIMEOUT;
                end
            end
            ST_CHECK: begin
                if (frame_good) begin
                    state_nxt = ST_IDLE;
                end else begin
                    state_nxt = ST_FAIL;
                    fail_go   = 1'b1;
                    fail_code = ERR_CSUM;
                end
            end
            // err is raised on entry to FAIL only when no retry remains
            ST_FAIL:  state_nxt = err ? ST_IDLE : ST_GAP;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    assign trig_go = (state_nxt == ST_TRIG);

`ifdef DHT11_SCHED_RETRY_EN
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    logic [RW-1:0] retry_cnt;

    assign retry_left = (retry_cnt != RW'(MAX_RETRY));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retry_cnt <= '0;
        end else if (state == ST_CHECK && frame_good) begin
            retry_cnt <= '0;
        end else if (fail_go) begin
            retry_cnt <= retry_left ? retry_cnt + RW'(1) : '0;
        end
    end
`else
    logic unused_retry;
    assign unused_retry = (MAX_RETRY != 0);
    assign retry_left   = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            pend      <= 1'b0;
            gap_cnt   <= GAP_MAX;
            gap_skip  <= 1'b0;
            per_cnt   <= '0;
            to_cnt    <= '0;
            frame_q   <= '0;
            start     <= 1'b0;
            busy      <= 1'b0;
            upd       <= 1'b0;
            err       <= 1'b0;
            err_code  <= ERR_NONE;
            valid     <= 1'b0;
            humid     <= '0;
            humid_dec <= '0;
            temp      <= '0;
            temp_dec  <= '0;
        end else begin
            state <= state_nxt;
            start <= trig_go;
            busy  <= (state_nxt != ST_IDLE);
            upd   <= 1'b0;
            err   <= 1'b0;
            pend  <= req | (per_wrap & auto_en) | (pend & ~trig_go);

            if (tick) per_cnt <= (per_cnt == PER_MAX) ? '0 : per_cnt + PER_W'(1);

            // the partial ms in which start fired is skipped, so spacing is whole ms
            if (trig_go) begin
                gap_cnt  <= '0;
                gap_skip <= 1'b1;
            end else if (tick) begin
                if (gap_skip)     gap_skip <= 1'b0;
                else if (!gap_ok) gap_cnt  <= gap_cnt + GAP_W'(1);
            end

            if (trig_go) begin
                to_cnt <= '0;
            end else if (tick && !to_hit && (state == ST_TRIG || state == ST_WAIT)) begin
                to_cnt <= to_cnt + TO_W'(1);
            end

            if (state == ST_WAIT && done) frame_q <= frame;

            if (state == ST_CHECK && frame_good) begin
                upd       <= 1'b1;
                valid     <= 1'b1;
                humid     <= frame_q[RH_INT_LSB +: 8];
                humid_dec <= frame_q[RH_DEC_LSB +: 8];
                temp      <= frame_q[T_INT_LSB +: 8];
                temp_dec  <= frame_q[T_DEC_LSB +: 8];
            end

            if (fail_go && !retry_left) begin
                err      <= 1'b1;
                err_code <= fail_code;
            end
        end
    end

endmodule

// File: tb/tb_dht11_sched.sv
// Directed bench for dht11_sched at 100 cycles/ms, 10 ms spacing, 5 ms timeout, 20 ms period.
// Expectations follow DHT11_SCHED_RETRY_EN when that macro is defined.
module tb_dht11_sched;
    localparam int CLK_HZ    = 100_000;
    localparam int MIN_MS    = 10;
    localparam int TO_MS     = 5;
    localparam int PER_MS    = 20;
    localparam int MAX_RETRY = 2;
`ifdef DHT11_SCHED_RETRY_EN
    localparam int ATTEMPTS = MAX_RETRY + 1;
`else
    localparam int ATTEMPTS = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_n, req, auto_en, done;
    logic [39:0] frame;
    logic        start, valid, upd, err, busy;
    logic [7:0]  humid, humid_dec, temp, temp_dec;
    logic [1:0]  err_code;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int n_start = 0;
    int n_upd = 0;
    int n_err = 0;
    int last_start = -1;
    int min_space = 1_000_000;
    int first_start = -1;

    dht11_sched #(
        .CLK_HZ(CLK_HZ), .MIN_INTERVAL_MS(MIN_MS), .PERIOD_MS(PER_MS),
        .TIMEOUT_MS(TO_MS), .MAX_RETRY(MAX_RETRY)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .auto_en(auto_en), .start(start),
        .done(done), .frame(frame), .humid(humid), .humid_dec(humid_dec),
        .temp(temp), .temp_dec(temp_dec), .valid(valid), .upd(upd), .err(err),
        .err_code(err_code), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst_n) begin
            last_start <= -1;
        end else begin
            if (start) begin
                if (last_start >= 0 && cyc - last_start < min_space) min_space <= cyc - last_start;
                last_start <= cyc;
                n_start    <= n_start + 1;
            end
            if (upd) n_upd <= n_upd + 1;
            if (err) n_err <= n_err + 1;
        end
    end

    // which: 0 start, 1 upd, 2 err; at = -1 when the budget expires
    task automatic wait_for(input int which, input int max_cyc, output int at);
        at = -1;
        for (int i = 0; i < max_cyc; i++) begin
            if ((which == 0 && start) || (which == 1 && upd) || (which == 2 && err)) begin
                at = cyc;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic pulse_req(output int rc);
        req = 1'b1;
        rc  = cyc;
        @(negedge clk);
        req = 1'b0;
    endtask

    task automatic send_done(input logic [39:0] f, output int dc);
        done  = 1'b1;
        frame = f;
        dc    = cyc;
        @(negedge clk);
        done  = 1'b0;
        frame = '0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; req = 1'b0; auto_en = 1'b0; done = 1'b0; frame = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({start, upd, err, busy, valid} !== 5'b0)
            begin errors++; $display("FAIL reset_ctrl: got %b expected 00000", {start, upd, err, busy, valid}); end
        checks++;
        if (err_code !== 2'b00) begin errors++; $display("FAIL reset_err_code: got %b expected 00", err_code); end
        checks++;
        if ({humid, humid_dec, temp, temp_dec} !== 32'h0)
            begin errors++; $display("FAIL reset_data: got %h expected 0", {humid, humid_dec, temp, temp_dec}); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single;
        int rc, sc, dc, uc, stray;
        send_done(40'h35_00_18_00_4D, dc);
        wait_for(1, 6, stray);
        checks++;
        if (stray !== -1) begin errors++; $display("FAIL idle_done_ignored: upd at %0d expected none", stray); end
        pulse_req(rc);
        wait_for(0, 10, sc);
        first_start = sc;
        checks++;
        if (sc - rc !== 2) begin errors++; $display("FAIL req_to_start: got %0d expected 2", sc - rc); end
        @(negedge clk);
        checks++;
        if (start !== 1'b0) begin errors++; $display("FAIL start_width: got %b expected 0", start); end
        @(negedge clk);
        send_done(40'h35_00_18_00_4D, dc);
        wait_for(1, 10, uc);
        checks++;
        if (uc - dc !== 2) begin errors++; $display("FAIL done_to_upd: got %0d expected 2", uc - dc); end
        checks++;
        if ({humid, humid_dec, temp, temp_dec, valid} !== {32'h35001800, 1'b1})
            begin errors++; $display("FAIL data1: got %h/%b expected 35001800/1", {humid, humid_dec, temp, temp_dec}, valid); end
        @(negedge clk);
        checks++;
        if ({upd, busy} !== 2'b00) begin errors++; $display("FAIL upd_width_idle: got %b expected 00", {upd, busy}); end
    endtask

    task automatic test_spacing;
        int rc, sc, dc, uc, low;
        pulse_req(rc);
        sc  = -1;
        low = 0;
        for (int i = 0; i < 1500; i++) begin
            if (cyc >= rc + 2 && busy !== 1'b1) low++;
            if (start) begin sc = cyc; break; end
            @(negedge clk);
        end
        checks++;
        if (sc < 0 || sc - first_start < 1000)
            begin errors++; $display("FAIL spacing: got %0d expected >= 1000", sc - first_start); end
        checks++;
        if (low !== 0) begin errors++; $display("FAIL busy_in_gap: got %0d low cycles expected 0", low); end
        @(negedge clk); @(negedge clk);
        send_done(40'h40_05_1A_03_62, dc);
        wait_for(1, 10, uc);
        checks++;
        if (uc < 0 || {humid, humid_dec, temp, temp_dec} !== 32'h40051A03)
            begin errors++; $display("FAIL data2: got %h expected 40051a03", {humid, humid_dec, temp, temp_dec}); end
    endtask

    task automatic test_timeout;
        int rc, ec, n0;
        n0 = n_start;
        pulse_req(rc);
        wait_for(2, 5000, ec);
        checks++;
        if (n_start - n0 !== ATTEMPTS)
            begin errors++; $display("FAIL timeout_attempts: got %0d expected %0d", n_start - n0, ATTEMPTS); end
        checks++;
        if (ec < 0 || ec - last_start < 400 || ec - last_start > 510)
            begin errors++; $display("FAIL timeout_delay: got %0d expected 400..510", ec - last_start); end
        checks++;
        if (err_code !== 2'b01) begin errors++; $display("FAIL timeout_code: got %b expected 01", err_code); end
        checks++;
        if ({humid, temp, valid} !== {16'h401A, 1'b1})
            begin errors++; $display("FAIL timeout_keeps_data: got %h/%b expected 401a/1", {humid, temp}, valid); end
        @(negedge clk);
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL err_width: got %b expected 0", err); end
    endtask

    task automatic test_checksum;
        int rc, sc, dc, ec, u0;
        u0 = n_upd;
        dc = -100;
        pulse_req(rc);
        for (int a = 0; a < ATTEMPTS; a++) begin
            wait_for(0, 1500, sc);
            checks++;
            if (sc < 0) begin errors++; $display("FAIL csum_start_%0d: got none expected start", a); end
            @(negedge clk); @(negedge clk);
            send_done(40'h35_00_18_00_4C, dc);
        end
        wait_for(2, 10, ec);
        checks++;
        if (ec - dc !== 2) begin errors++; $display("FAIL csum_done_to_err: got %0d expected 2", ec - dc); end
        checks++;
        if (err_code !== 2'b10) begin errors++; $display("FAIL csum_code: got %b expected 10", err_code); end
        checks++;
        if ({humid, humid_dec, temp, temp_dec, valid} !== {32'h40051A03, 1'b1} || n_upd !== u0)
            begin errors++; $display("FAIL csum_keeps_data: got %h/%b upd %0d expected 40051a03/1 upd 0",
                                     {humid, humid_dec, temp, temp_dec}, valid, n_upd - u0); end
    endtask

    task automatic test_auto;
        int s1, s2, s3, sx, dc, n0;
        repeat (1200) @(negedge clk);
        auto_en = 1'b1;
        wait_for(0, 2200, s1);
        @(negedge clk); @(negedge clk);
        send_done(40'h22_00_19_00_3B, dc);
        wait_for(0, 2200, s2);
        @(negedge clk); @(negedge clk);
        send_done(40'h22_00_19_00_3B, dc);
        wait_for(0, 2200, s3);
        auto_en = 1'b0;
        checks++;
        if (s1 < 0 || s2 - s1 !== 2000) begin errors++; $display("FAIL auto_period1: got %0d expected 2000", s2 - s1); end
        checks++;
        if (s2 < 0 || s3 - s2 !== 2000) begin errors++; $display("FAIL auto_period2: got %0d expected 2000", s3 - s2); end
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            req = 1'b1; @(negedge clk);
            req = 1'b0; @(negedge clk);
        end
        n0 = n_start;
        send_done(40'h22_00_19_00_3B, dc);
        wait_for(0, 1500, sx);
        @(negedge clk); @(negedge clk);
        send_done(40'h22_00_19_00_3B, dc);
        repeat (1500) @(negedge clk);
        checks++;
        if (sx < 0 || n_start - n0 !== 1)
            begin errors++; $display("FAIL req_collapse: got %0d starts expected 1", n_start - n0); end
        checks++;
        if ({humid, temp, valid} !== {16'h2219, 1'b1})
            begin errors++; $display("FAIL auto_data: got %h/%b expected 2219/1", {humid, temp}, valid); end
    endtask

    task automatic test_reset_mid;
        int rc, sc, dc, uc, e0;
        pulse_req(rc);
        wait_for(0, 1500, sc);
        @(negedge clk); @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({start, upd, err, busy, valid, err_code} !== 7'b0)
            begin errors++; $display("FAIL async_reset_ctrl: got %b expected 0", {start, upd, err, busy, valid, err_code}); end
        checks++;
        if ({humid, humid_dec, temp, temp_dec} !== 32'h0)
            begin errors++; $display("FAIL async_reset_data: got %h expected 0", {humid, humid_dec, temp, temp_dec}); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        e0 = n_err;
        pulse_req(rc);
        wait_for(0, 10, sc);
        checks++;
        if (sc - rc !== 2) begin errors++; $display("FAIL post_reset_start: got %0d expected 2", sc - rc); end
        @(negedge clk); @(negedge clk);
        send_done(40'h35_00_18_00_4D, dc);
        wait_for(1, 10, uc);
        repeat (20) @(negedge clk);
        checks++;
        if (uc < 0 || n_err !== e0 || err_code !== 2'b00)
            begin errors++; $display("FAIL stale_err: got %0d errs code %b expected 0/00", n_err - e0, err_code); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_spacing();
        test_timeout();
        test_checksum();
        test_auto();
        test_reset_mid();
        checks++;
        if (min_space < 1000) begin errors++; $display("FAIL min_spacing: got %0d expected >= 1000", min_space); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
